// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter that shares one line-wide main memory between the
// instruction cache (port 0) and the data cache (port 1). It serialises
// line reads and write-backs with round-robin fairness. Each transaction is
// latched at arbitration time, so main_mem sees stable request, address and
// data even if the requester misbehaves. Read data is registered per port.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   pN_rd_req / pN_wr_req      line read / write request, held until pN_gnt
//   pN_addr, pN_wr_line        line address and write data for port N
//   pN_gnt                     transaction-complete pulse (combinational)
//   pN_rd_line                 last line read for port N (registered)
//   pN_cnt                     completed transactions for port N, saturating
//   mem_rd_req / mem_wr_req    request to main_mem (exactly one high in BUSY)
//   mem_addr, mem_wr_line      latched address / write line (0 outside BUSY)
//   mem_gnt, mem_rd_line       completion and read data from main_mem
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate between pending requests, latch the winner
// BUSY  | latched transaction outstanding at main_mem, wait for mem_gnt
// GAP   | one forced idle cycle so the served port can drop its request

module mem_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 8,
    parameter int CNT_W         = 16
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              p0_rd_req,
    input  logic                              p0_wr_req,
    input  logic [ADDR_LEN-1:0]               p0_addr,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]    p0_wr_line,
    output logic                              p0_gnt,
    output logic [(32<<LINE_ADDR_LEN)-1:0]    p0_rd_line,
    output logic [CNT_W-1:0]                  p0_cnt,

    input  logic                              p1_rd_req,
    input  logic                              p1_wr_req,
    input  logic [ADDR_LEN-1:0]               p1_addr,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]    p1_wr_line,
    output logic                              p1_gnt,
    output logic [(32<<LINE_ADDR_LEN)-1:0]    p1_rd_line,
    output logic [CNT_W-1:0]                  p1_cnt,

    output logic                              mem_rd_req,
    output logic                              mem_wr_req,
    output logic [ADDR_LEN-1:0]               mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]    mem_wr_line,
    input  logic                              mem_gnt,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]    mem_rd_line
);

    localparam int LINE_W = 32 << LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Transaction latch
    logic                owner;
    logic                op_wr;
    logic [ADDR_LEN-1:0] lat_addr;
    logic [LINE_W-1:0]   lat_line;

    // Port that completed the previous transaction; reset to 1 so that
    // port 0 wins the very first tie.
    logic                last_owner;

    logic                req0;
    logic                req1;
    logic                pick;
    logic                latch_en;
    logic                done;

    assign req0 = p0_rd_req | p0_wr_req;
    assign req1 = p1_rd_req | p1_wr_req;

    always_comb begin
        state_nxt   = state;
        pick        = 1'b0;
        latch_en    = 1'b0;
        done        = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;

        // On a tie the port that was not served last goes next.
        if (req0 && req1) begin
            pick = ~last_owner;
        end else if (req1) begin
            pick = 1'b1;
        end

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    latch_en  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_rd_req  = ~op_wr;
                mem_wr_req  = op_wr;
                mem_addr    = lat_addr;
                mem_wr_line = lat_line;
                if (mem_gnt) begin
                    done      = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A completion that coincides with reset is abandoned, so the
        // requester never sees a grant for it.
        p0_gnt = done & ~owner & ~rst;
        p1_gnt = done &  owner & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            op_wr      <= 1'b0;
            lat_addr   <= '0;
            lat_line   <= '0;
            last_owner <= 1'b1;
            p0_rd_line <= '0;
            p1_rd_line <= '0;
            p0_cnt     <= '0;
            p1_cnt     <= '0;
        end else begin
            state <= state_nxt;

            if (latch_en) begin
                owner    <= pick;
                // A write request takes precedence over a simultaneous read.
                op_wr    <= pick ? p1_wr_req  : p0_wr_req;
                lat_addr <= pick ? p1_addr    : p0_addr;
                lat_line <= pick ? p1_wr_line : p0_wr_line;
            end

            if (done) begin
                last_owner <= owner;
                if (!owner) begin
                    if (p0_cnt != {CNT_W{1'b1}}) begin
                        p0_cnt <= p0_cnt + 1'b1;
                    end
                    if (!op_wr) begin
                        p0_rd_line <= mem_rd_line;
                    end
                end else begin
                    if (p1_cnt != {CNT_W{1'b1}}) begin
                        p1_cnt <= p1_cnt + 1'b1;
                    end
                    if (!op_wr) begin
                        p1_rd_line <= mem_rd_line;
                    end
                end
            end
        end
    end

endmodule
